score_tracker: RTL and testbench

//   Parametrised successor to the whack-a-mole 5-bit hit counter. Edge-detects
//   hit/miss strobes from the mole game FSM and keeps a saturating score.

---
 rtl/score_tracker_if.sv | 26 ++
 rtl/score_tracker.sv | 103 ++++++++++
 tb/tb_score_tracker.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_tracker_if.sv
// Score tracker bus: game-side strobes in, score/status out.
interface score_tracker_if #(
  parameter int SCORE_W = 8
);
  logic               clear;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic [2:0]         mult;
  logic [2:0]         combo_cnt;
  logic               new_high;
  logic               saturated;

  // Game FSM / display side
  modport master (
    output clear, hit, miss,
    input  score, high_score, mult, combo_cnt, new_high, saturated
  );

  // Score tracker side
  modport slave (
    input  clear, hit, miss,
    output score, high_score, mult, combo_cnt, new_high, saturated
  );
endinterface

// File: rtl/score_tracker.sv
// Saturating game score with combo multiplier, miss penalty and a high score
// that survives a new-game clear. Hit/miss are levels; only rising edges count.
module score_tracker #(
  parameter int SCORE_W      = 8,
  parameter int COMBO_LEN    = 4,
  parameter int MAX_MULT     = 4,
  parameter int MISS_PENALTY = 1
) (
  input  logic             clk,
  input  logic             reset,
  score_tracker_if.slave   bus
);

  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] PENALTY    = SCORE_W'(MISS_PENALTY);
  localparam logic [2:0]         COMBO_LAST = 3'(COMBO_LEN - 1);
  localparam logic [2:0]         MULT_MAX   = 3'(MAX_MULT);

  logic               r_hit_q;
  logic               r_miss_q;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high;
  logic [2:0]         r_mult;
  logic [2:0]         r_combo;
  logic               r_new_high;

  logic               w_hit_ev;
  logic               w_miss_ev;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [2:0]         w_mult_nxt;
  logic [2:0]         w_combo_nxt;

  assign w_hit_ev  = bus.hit  & ~r_hit_q;
  assign w_miss_ev = bus.miss & ~r_miss_q;

  // One extra bit catches the carry so the score clamps instead of wrapping.
  assign w_sum = {1'b0, r_score} + (SCORE_W+1)'(r_mult);

  // Next score/multiplier/combo: clear beats miss, miss beats hit.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_score_nxt = r_score;
    w_mult_nxt  = r_mult;
    w_combo_nxt = r_combo;
    if (bus.clear) begin
      w_score_nxt = '0;
      w_mult_nxt  = 3'd1;
      w_combo_nxt = '0;
    end else if (w_miss_ev) begin
      w_score_nxt = (r_score >= PENALTY) ? (r_score - PENALTY) : '0;
      w_mult_nxt  = 3'd1;
      w_combo_nxt = '0;
    end else if (w_hit_ev) begin
      w_score_nxt = w_sum[SCORE_W] ? SCORE_MAX : w_sum[SCORE_W-1:0];
      if (r_combo == COMBO_LAST) begin
        w_combo_nxt = '0;
        w_mult_nxt  = (r_mult >= MULT_MAX) ? MULT_MAX : (r_mult + 3'd1);
      end else begin
        w_combo_nxt = r_combo + 3'd1;
      end
    end
  end

  // Edge-detect history and game state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      r_hit_q  <= 1'b0;
      r_miss_q <= 1'b0;
      r_score  <= '0;
      r_mult   <= 3'd1;
      r_combo  <= '0;
    end else begin
      r_hit_q  <= bus.hit;
      r_miss_q <= bus.miss;
      r_score  <= w_score_nxt;
      r_mult   <= w_mult_nxt;
      r_combo  <= w_combo_nxt;
    end
  end

  // High score follows the new score only when strictly better; pulse on change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_high     <= '0;
      r_new_high <= 1'b0;
    end else if (w_score_nxt > r_high) begin
      r_high     <= w_score_nxt;
      r_new_high <= 1'b1;
    end else begin
      r_new_high <= 1'b0;
    end
  end

  assign bus.score      = r_score;
  assign bus.high_score = r_high;
  assign bus.mult       = r_mult;
  assign bus.combo_cnt  = r_combo;
  assign bus.new_high   = r_new_high;
  assign bus.saturated  = (r_score == SCORE_MAX);

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: an 8-bit and a 4-bit instance driven by directed
// sequences, compared every cycle against an integer model of the game rules,
// plus hand-computed literal expectations at key points.
module tb_score_tracker;

  localparam int COMBO_LEN    = 4;
  localparam int MAX_MULT     = 4;
  localparam int MISS_PENALTY = 1;

  logic clk = 1'b0;
  logic reset;

  score_tracker_if #(.SCORE_W(8)) bus8 ();
  score_tracker_if #(.SCORE_W(4)) bus4 ();

  score_tracker #(
    .SCORE_W(8), .COMBO_LEN(COMBO_LEN), .MAX_MULT(MAX_MULT), .MISS_PENALTY(MISS_PENALTY)
  ) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  score_tracker #(
    .SCORE_W(4), .COMBO_LEN(COMBO_LEN), .MAX_MULT(MAX_MULT), .MISS_PENALTY(MISS_PENALTY)
  ) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nh_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0: 8-bit, 1: 4-bit) ----------
  int m_score [2];
  int m_high  [2];
  int m_mult  [2];
  int m_combo [2];
  bit m_nh    [2];
  bit m_hq    [2];
  bit m_mq    [2];
  int m_top   [2] = '{255, 15};

  task automatic model_reset(input int k);
    m_score[k] = 0; m_high[k] = 0; m_mult[k] = 1; m_combo[k] = 0;
    m_nh[k] = 0; m_hq[k] = 0; m_mq[k] = 0;
  endtask

  task automatic model_step(input int k, input bit h, input bit m, input bit c);
    bit hit_rise;
    bit miss_rise;
    hit_rise  = h && !m_hq[k];
    miss_rise = m && !m_mq[k];
    if (c) begin
      m_score[k] = 0; m_mult[k] = 1; m_combo[k] = 0;
    end else if (miss_rise) begin
      m_score[k] = (m_score[k] > MISS_PENALTY) ? m_score[k] - MISS_PENALTY : 0;
      m_mult[k] = 1; m_combo[k] = 0;
    end else if (hit_rise) begin
      m_score[k] = m_score[k] + m_mult[k];
      if (m_score[k] > m_top[k]) m_score[k] = m_top[k];
      m_combo[k]++;
      if (m_combo[k] == COMBO_LEN) begin
        m_combo[k] = 0;
        if (m_mult[k] < MAX_MULT) m_mult[k]++;
      end
    end
    m_nh[k] = (m_score[k] > m_high[k]);
    if (m_nh[k]) m_high[k] = m_score[k];
    m_hq[k] = h;
    m_mq[k] = m;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, bus8.hit, bus8.miss, bus8.clear);
      model_step(1, bus4.hit, bus4.miss, bus4.clear);
    end
  end

  // ---------------- per-cycle compare, away from the active edge -----------
  task automatic cmp(input string tag, input int k, input logic [31:0] sc, input logic [31:0] hs,
                     input logic [31:0] mu, input logic [31:0] cb, input logic nh, input logic sat);
    check({tag, ".score"},      sc, m_score[k]);
    check({tag, ".high_score"}, hs, m_high[k]);
    check({tag, ".mult"},       mu, m_mult[k]);
    check({tag, ".combo_cnt"},  cb, m_combo[k]);
    check({tag, ".new_high"},   32'(nh), 32'(m_nh[k]));
    check({tag, ".saturated"},  32'(sat), 32'(m_score[k] == m_top[k]));
  endtask

  always @(negedge clk) begin
    cmp("dut8", 0, 32'(bus8.score), 32'(bus8.high_score), 32'(bus8.mult), 32'(bus8.combo_cnt),
        bus8.new_high, bus8.saturated);
    cmp("dut4", 1, 32'(bus4.score), 32'(bus4.high_score), 32'(bus4.mult), 32'(bus4.combo_cnt),
        bus4.new_high, bus4.saturated);
    if (bus8.new_high) nh_seen++;
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse8(input bit h, input bit m);
    bus8.hit = h; bus8.miss = m;
    tick();
    bus8.hit = 1'b0; bus8.miss = 1'b0;
    tick();
  endtask

  task automatic hits8(input int n);
    repeat (n) pulse8(1'b1, 1'b0);
  endtask

  task automatic pulse4(input bit h, input bit m);
    bus4.hit = h; bus4.miss = m;
    tick();
    bus4.hit = 1'b0; bus4.miss = 1'b0;
    tick();
  endtask

  task automatic hits4(input int n);
    repeat (n) pulse4(1'b1, 1'b0);
  endtask

  task automatic clear8();
    bus8.clear = 1'b1;
    tick();
    bus8.clear = 1'b0;
    tick();
  endtask

  // Climb 0 -> 1,2,3,4 (x2),6,8, miss to 7 (x1), 8, 9.
  task automatic climb_to_9();
    hits8(6);
    pulse8(1'b0, 1'b1);
    hits8(2);
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    reset = 1'b1;
    bus8.clear = 1'b0; bus8.hit = 1'b0; bus8.miss = 1'b0;
    bus4.clear = 1'b0; bus4.hit = 1'b0; bus4.miss = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst.score", 32'(bus8.score), 0);
    check("rst.mult",  32'(bus8.mult), 1);
    check("rst.high",  32'(bus8.high_score), 0);

    // Four hits at x1 then four at x2.
    hits8(1);
    check("hit1.score", 32'(bus8.score), 1);
    hits8(3);
    check("hit4.score", 32'(bus8.score), 4);
    check("hit4.mult",  32'(bus8.mult), 2);
    hits8(4);
    check("hit8.score", 32'(bus8.score), 12);
    check("hit8.mult",  32'(bus8.mult), 3);

    // Build a mid-game state of 37 at x3: 15,18,21,24(x4), miss 23, miss 22,
    // 23..26(x2), 28..34(x3), 37.
    hits8(4);
    check("x4.score", 32'(bus8.score), 24);
    check("x4.mult",  32'(bus8.mult), 4);
    pulse8(1'b0, 1'b1);
    pulse8(1'b0, 1'b1);
    check("miss2.score", 32'(bus8.score), 22);
    hits8(9);
    check("mid.score", 32'(bus8.score), 37);
    check("mid.mult",  32'(bus8.mult), 3);
    check("mid.combo", 32'(bus8.combo_cnt), 1);

    // Asynchronous reset between clock edges.
    #3;
    reset = 1'b1;
    #1;
    check("async.score", 32'(bus8.score), 0);
    check("async.high",  32'(bus8.high_score), 0);
    check("async.mult",  32'(bus8.mult), 1);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Held hit counts once; misses at zero stay at zero.
    bus8.hit = 1'b1;
    repeat (10) tick();
    bus8.hit = 1'b0;
    tick();
    check("held.score", 32'(bus8.score), 1);
    pulse8(1'b0, 1'b1);
    pulse8(1'b0, 1'b1);
    check("miss0.score", 32'(bus8.score), 0);
    check("miss0.mult",  32'(bus8.mult), 1);
    check("miss0.combo", 32'(bus8.combo_cnt), 0);

    // Simultaneous hit and miss at score 5, x2: 1,2, miss 1, 2,3,4,5(x2).
    hits8(2);
    pulse8(1'b0, 1'b1);
    hits8(4);
    check("pre_both.score", 32'(bus8.score), 5);
    check("pre_both.mult",  32'(bus8.mult), 2);
    pulse8(1'b1, 1'b1);
    check("both.score", 32'(bus8.score), 4);
    check("both.mult",  32'(bus8.mult), 1);
    check("both.combo", 32'(bus8.combo_cnt), 0);

    // High score across a clear.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    nh_seen = 0;
    climb_to_9();
    check("climb1.score", 32'(bus8.score), 9);
    check("climb1.high",  32'(bus8.high_score), 9);
    check("climb1.pulses", 32'(nh_seen), 7);
    clear8();
    check("clear.score", 32'(bus8.score), 0);
    check("clear.high",  32'(bus8.high_score), 9);
    check("clear.mult",  32'(bus8.mult), 1);
    nh_seen = 0;
    climb_to_9();
    check("climb2.score",  32'(bus8.score), 9);
    check("climb2.pulses", 32'(nh_seen), 0);
    hits8(1);
    check("beat.score",  32'(bus8.score), 10);
    check("beat.high",   32'(bus8.high_score), 10);
    check("beat.pulses", 32'(nh_seen), 1);

    // Saturation on the 4-bit instance: 1,2,3, miss 2, 3..6(x2), 8..14(x3).
    hits4(3);
    pulse4(1'b0, 1'b1);
    hits4(8);
    check("w4.score", 32'(bus4.score), 14);
    check("w4.mult",  32'(bus4.mult), 3);
    hits4(1);
    check("w4.sat_score", 32'(bus4.score), 15);
    check("w4.saturated", 32'(bus4.saturated), 1);
    hits4(1);
    check("w4.hold_score", 32'(bus4.score), 15);
    check("w4.hold_high",  32'(bus4.high_score), 15);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
